// File: rtl/gpio_irq_unit.sv
// rtl/gpio_irq_unit.sv - GPIO input synchronizer, debounce, edge detect and interrupt unit
//
// Purpose:
//   Watches the 32 GPIO pins shared with the GPIO controller. Each pin is
//   brought into the clk domain by a two-flop synchronizer. It is then
//   debounced on a prescaled sample tick and edge-detected. Enabled rising and
//   falling edges latch into a pending register, and a single level interrupt
//   is raised while any pending bit is set.
//
// Parameters:
//   ADDR          base byte address of the 16-byte register window. It must be
//                 word aligned.
//   DEBOUNCE_DIV  sample-tick period in clk cycles (1..65535). A value of 1
//                 gives a tick every cycle.
//
// Ports:
//   clk    system clock; all logic runs on posedge
//   rst_n  synchronous active-low reset
//   addr   CPU bus byte address
//   data   CPU bus data; driven only during a selected read, otherwise high-Z
//   size   access size: 0=byte, 1=half, 2=word, 3=reserved
//   rw     0=read, 1=write
//   gpio   asynchronous pin levels
//   irq    registered level interrupt, set while any pending bit is set
//
// Register map (offsets from ADDR, word accesses only):
//   0x0 RISE_EN  RW
//   0x4 FALL_EN  RW
//   0x8 PENDING  read returns pending bits; writing a 1 clears that bit
//   0xC LEVEL    RO, debounced pin levels

module gpio_irq_unit #(
    parameter logic [31:0] ADDR         = 32'h8000_0010,
    parameter int unsigned DEBOUNCE_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic [1:0]  size,
    input  logic        rw,
    input  logic [31:0] gpio,
    output logic        irq
);

    localparam logic [15:0] DIV_LAST = 16'(DEBOUNCE_DIV - 1);

    localparam logic [1:0] REG_RISE_EN = 2'd0;
    localparam logic [1:0] REG_FALL_EN = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_LEVEL   = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    // The word offset is computed with one extra bit. If addr is below ADDR,
    // the subtraction wraps and the top bit is set. A single "upper bits are
    // zero" test therefore covers both ends of the window.
    logic [30:0] word_off;
    logic        in_win;
    logic        sel;
    logic [1:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;

    assign word_off = {1'b0, addr[31:2]} - {1'b0, ADDR[31:2]};
    assign in_win   = (word_off[30:2] == 29'd0);
    assign reg_idx  = word_off[1:0];
    assign sel      = in_win && (addr[1:0] == 2'b00) && (size == 2'd2);
    assign wr_en    = sel && rw;
    assign rd_en    = sel && !rw;
    assign wdata    = data;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] samp;
    logic [31:0] filt;
    logic [31:0] filt_q;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] pending;
    logic [31:0] rbuf;
    logic [15:0] count;

    logic        tick;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] clr;
    logic [31:0] stable;
    logic [31:0] rd_mux;

    // The bus drives data only while a selected read is held. The value seen
    // is the one captured into rbuf on the previous edge of that read.
    assign data = rd_en ? rbuf : 32'bz;

    // With DEBOUNCE_DIV=1, DIV_LAST is 0. The count then stays at 0 and tick
    // is high every cycle.
    assign tick = (count == DIV_LAST);

    assign rise = filt & ~filt_q;
    assign fall = ~filt & filt_q;

    // A pending bit is cleared only by writing a 1 to it. Set terms are ORed
    // in after the clear, so a new edge in the same cycle as a clear wins.
    assign clr = (wr_en && (reg_idx == REG_PENDING)) ? wdata : 32'd0;

    // A pin is accepted by the filter only when the sample taken on this
    // tick matches the sample from the previous tick.
    assign stable = ~(sync2 ^ samp);

    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            REG_RISE_EN: rd_mux = rise_en;
            REG_FALL_EN: rd_mux = fall_en;
            REG_PENDING: rd_mux = pending;
            REG_LEVEL:   rd_mux = filt;
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 32'd0;
            sync2   <= 32'd0;
            samp    <= 32'd0;
            filt    <= 32'd0;
            filt_q  <= 32'd0;
            rise_en <= 32'd0;
            fall_en <= 32'd0;
            pending <= 32'd0;
            rbuf    <= 32'd0;
            count   <= 16'd0;
            irq     <= 1'b0;
        end else begin
            sync1 <= gpio;
            sync2 <= sync1;

            count <= tick ? 16'd0 : count + 16'd1;

            if (tick) begin
                samp <= sync2;
                filt <= (filt & ~stable) | (sync2 & stable);
            end

            filt_q <= filt;

            if (wr_en && (reg_idx == REG_RISE_EN)) begin
                rise_en <= wdata;
            end
            if (wr_en && (reg_idx == REG_FALL_EN)) begin
                fall_en <= wdata;
            end

            pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);

            if (rd_en) begin
                rbuf <= rd_mux;
            end

            irq <= |pending;
        end
    end

endmodule

// File: tb/tb_gpio_irq_unit.sv
// tb/tb_gpio_irq_unit.sv - self-checking bench for gpio_irq_unit

module tb_gpio_irq_unit;

    localparam logic [31:0] A1 = 32'h8000_0010;
    localparam logic [31:0] A4 = 32'h8000_0100;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] addr   = 32'd0;
    logic [1:0]  size   = 2'd2;
    logic        rw     = 1'b0;
    logic [31:0] wdrv   = 32'd0;
    logic        wen    = 1'b0;
    logic [31:0] gpio_a = 32'd0;
    logic [31:0] gpio_b = 32'd0;
    logic        irq_a;
    logic        irq_b;
    wire  [31:0] data;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    assign data = wen ? wdrv : 32'bz;
    pullup (data);

    always #5 clk = ~clk;

    gpio_irq_unit #(.ADDR(A1), .DEBOUNCE_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
        .size(size), .rw(rw), .gpio(gpio_a), .irq(irq_a)
    );

    gpio_irq_unit #(.ADDR(A4), .DEBOUNCE_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
        .size(size), .rw(rw), .gpio(gpio_b), .irq(irq_b)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        addr = 32'd0;
        size = 2'd2;
        rw   = 1'b0;
        wen  = 1'b0;
        wdrv = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        addr = a; size = sz; rw = 1'b1; wdrv = d; wen = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        addr = a; size = sz; rw = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, data, e);
        idle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;

        // Reset-state and decode table. Unselected reads see the pull-up.
        vecs[0]  = '{A1 + 32'h0,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{A1 + 32'h4,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{A1 + 32'h8,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{A1 + 32'hC,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{A1 + 32'h0,  2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{A1 + 32'h2,  2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{A1 + 32'h10, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{A1 + 32'h4,  2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[8]  = '{A1 + 32'h0,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[9]  = '{A1 + 32'h4,  2'd2, 1'b0, 32'h0,         32'h0};
        vecs[10] = '{A1 + 32'h2,  2'd2, 1'b0, 32'h0,         32'hFFFF_FFFF};
        vecs[11] = '{A1 + 32'h0,  2'd0, 1'b0, 32'h0,         32'hFFFF_FFFF};
        vecs[12] = '{A1 + 32'h10, 2'd2, 1'b0, 32'h0,         32'hFFFF_FFFF};
        vecs[13] = '{A1 + 32'h8,  2'd3, 1'b0, 32'h0,         32'hFFFF_FFFF};
        vecs[14] = '{A1 + 32'h0,  2'd2, 1'b1, 32'hA5A5_0F0F, 32'h0};
        vecs[15] = '{A1 + 32'h0,  2'd2, 1'b0, 32'h0,         32'hA5A5_0F0F};
        vecs[16] = '{A1 + 32'h4,  2'd2, 1'b1, 32'h1234_5678, 32'h0};
        vecs[17] = '{A1 + 32'h4,  2'd2, 1'b0, 32'h0,         32'h1234_5678};
        vecs[18] = '{A1 + 32'hC,  2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[19] = '{A1 + 32'hC,  2'd2, 1'b0, 32'h0,         32'h0};

        idle();
        rst_n = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(2);

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq_a !== 1'b0) bad++;
        end
        check("irq_idle_cycles_high", bad, 0);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].sz, vecs[i].wd);
            else bus_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].sz, vecs[i].exp);
        end
        bus_write(A1 + 32'h0, 2'd2, 32'h0);
        bus_write(A1 + 32'h4, 2'd2, 32'h0);

        // Rising edge on pin 0: exact latency to irq, then W1C.
        bus_write(A1 + 32'h0, 2'd2, 32'h1);
        @(negedge clk);
        gpio_a[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("irq_after_e5", irq_a, 0);
        @(negedge clk);
        check("irq_after_e6", irq_a, 1);
        bus_read("pend_rise0", A1 + 32'h8, 2'd2, 32'h1);
        bus_write(A1 + 32'h8, 2'd2, 32'h1);
        check("irq_lag_after_clear", irq_a, 1);
        @(negedge clk);
        check("irq_after_clear", irq_a, 0);
        bus_read("pend_cleared", A1 + 32'h8, 2'd2, 32'h0);

        // Falling edge on pin 31 with only FALL_EN.
        bus_write(A1 + 32'h0, 2'd2, 32'h0);
        gpio_a[31] = 1'b1;
        wait_cyc(8);
        bus_read("pend_rise_disabled", A1 + 32'h8, 2'd2, 32'h0);
        bus_write(A1 + 32'h4, 2'd2, 32'h8000_0000);
        gpio_a[31] = 1'b0;
        wait_cyc(8);
        bus_read("pend_fall31", A1 + 32'h8, 2'd2, 32'h8000_0000);
        check("irq_fall31", irq_a, 1);
        gpio_a[31] = 1'b1;
        wait_cyc(8);
        bus_read("pend_rise31_ignored", A1 + 32'h8, 2'd2, 32'h8000_0000);
        bus_read("level_31_0", A1 + 32'hC, 2'd2, 32'h8000_0001);
        bus_write(A1 + 32'h4, 2'd2, 32'h0);
        bus_read("pend_kept_on_disable", A1 + 32'h8, 2'd2, 32'h8000_0000);
        bus_write(A1 + 32'h8, 2'd2, 32'h8000_0000);
        bus_read("pend_w1c_31", A1 + 32'h8, 2'd2, 32'h0);
        gpio_a[31] = 1'b0;
        wait_cyc(8);
        bus_write(A1 + 32'h4, 2'd2, 32'h8000_0000);
        bus_read("pend_not_retroactive", A1 + 32'h8, 2'd2, 32'h0);
        wait_cyc(2);
        check("irq_not_retroactive", irq_a, 0);
        bus_write(A1 + 32'h4, 2'd2, 32'h0);

        // Debounce with DEBOUNCE_DIV=4 on the second instance.
        bus_write(A4 + 32'h0, 2'd2, 32'h20);
        @(negedge clk);
        gpio_b[5] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_b[5] = 1'b0;
        wait_cyc(20);
        bus_read("div4_level_glitch", A4 + 32'hC, 2'd2, 32'h0);
        bus_read("div4_pend_glitch", A4 + 32'h8, 2'd2, 32'h0);
        check("div4_irq_glitch", irq_b, 0);
        @(negedge clk);
        gpio_b[5] = 1'b1;
        repeat (12) @(negedge clk);
        gpio_b[5] = 1'b0;
        wait_cyc(20);
        bus_read("div4_pend_long", A4 + 32'h8, 2'd2, 32'h20);
        check("div4_irq_long", irq_b, 1);

        // Clear and set of pending bit 0 on the same edge: set wins.
        bus_write(A1 + 32'h0, 2'd2, 32'h1);
        gpio_a[0] = 1'b0;
        wait_cyc(8);
        gpio_a[0] = 1'b1;
        wait_cyc(8);
        bus_read("pend0_before_collide", A1 + 32'h8, 2'd2, 32'h1);
        gpio_a[0] = 1'b0;
        wait_cyc(8);
        @(negedge clk);
        gpio_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        addr = A1 + 32'h8; size = 2'd2; rw = 1'b1; wdrv = 32'h1; wen = 1'b1;
        @(negedge clk);
        idle();
        bus_read("pend0_set_wins", A1 + 32'h8, 2'd2, 32'h1);
        bus_write(A1 + 32'h8, 2'd2, 32'h1);
        bus_read("pend0_plain_clear", A1 + 32'h8, 2'd2, 32'h0);

        // Reset in the middle of a read with PENDING=0xFF.
        bus_write(A1 + 32'h0, 2'd2, 32'hFF);
        gpio_a = 32'h0;
        wait_cyc(8);
        bus_write(A1 + 32'h8, 2'd2, 32'hFFFF_FFFF);
        gpio_a = 32'hFF;
        wait_cyc(8);
        bus_read("pend_ff", A1 + 32'h8, 2'd2, 32'hFF);
        check("irq_ff", irq_a, 1);
        @(negedge clk);
        addr = A1 + 32'h8; size = 2'd2; rw = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rd_during_reset", data, 32'h0);
        check("irq_during_reset", irq_a, 0);
        idle();
        rst_n = 1'b1;
        wait_cyc(8);
        bus_read("pend_after_reset", A1 + 32'h8, 2'd2, 32'h0);
        bus_read("rise_en_after_reset", A1 + 32'h0, 2'd2, 32'h0);
        bus_read("level_after_reset", A1 + 32'hC, 2'd2, 32'hFF);
        check("irq_after_reset", irq_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
